// File: rtl/collision_monitor.sv
// collision_monitor
//   Checks the player bounding box against the obstacle bounding box and
//   runs the PLAY/HIT/OVER game FSM. It also tracks lives and the dodge
//   score. The collision output goes back to obstacle control and stops
//   obstacle motion while a hit or game-over is active.
//
//   Optional feature macro: HIT_COOLDOWN_EN
//     When defined, HIT lasts COOLDOWN_TICKS game ticks. A new hit is then
//     accepted only after the overlap has cleared once (the armed flag).
//     When undefined, HIT ends on the first game tick with no overlap.
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     game_en                      one-clk game tick enable
//     restart                      one-clk pulse, restarts the game
//     player_x_pos/player_y_pos    player top-left corner
//     obstacle_x_pos/obstacle_y_pos obstacle top-left corner
//     obstacle_width/height        obstacle size
//     collision                    high in HIT and OVER
//     hit_pulse                    one-clk pulse per accepted hit
//     lives                        remaining lives
//     score                        obstacles dodged, saturating
//     game_over                    high in OVER
//     state                        PLAY=0, HIT=1, OVER=2
module collision_monitor #(
    parameter logic [9:0] PLAYER_WIDTH   = 10'd40,
    parameter logic [9:0] PLAYER_HEIGHT  = 10'd20,
    parameter logic [2:0] START_LIVES    = 3'd3,
    parameter int         SCORE_W        = 8,
    parameter logic [5:0] COOLDOWN_TICKS = 6'd30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic               restart,
    input  logic [9:0]         player_x_pos,
    input  logic [9:0]         player_y_pos,
    input  logic [9:0]         obstacle_x_pos,
    input  logic [9:0]         obstacle_y_pos,
    input  logic [9:0]         obstacle_width,
    input  logic [9:0]         obstacle_height,
    output logic               collision,
    output logic               hit_pulse,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HIT  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               hit_d;
    logic               collision_q, game_over_q, hit_q;
    logic               overlap, overlap_q;
    logic [9:0]         y_q;
    logic               wrap;
    logic               hit_ok;

    // Compare in 11 bits so that position + size cannot wrap around.
    logic [10:0] px, py, ox, oy;
    assign px = {1'b0, player_x_pos};
    assign py = {1'b0, player_y_pos};
    assign ox = {1'b0, obstacle_x_pos};
    assign oy = {1'b0, obstacle_y_pos};

    assign overlap = (ox < px + {1'b0, PLAYER_WIDTH})  &&
                     (px < ox + {1'b0, obstacle_width}) &&
                     (oy < py + {1'b0, PLAYER_HEIGHT}) &&
                     (py < oy + {1'b0, obstacle_height});

    // The obstacle moving back from the bottom of the screen to the top
    // counts as one dodged obstacle.
    assign wrap = (obstacle_y_pos < y_q);

`ifdef HIT_COOLDOWN_EN
    logic [5:0] cd_q, cd_d;
    logic       armed_q, armed_d;
    assign hit_ok = game_en && overlap_q && armed_q;
`else
    assign hit_ok = game_en && overlap_q;
    logic unused_cd;
    assign unused_cd = ^COOLDOWN_TICKS;
`endif

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        hit_d   = 1'b0;
`ifdef HIT_COOLDOWN_EN
        cd_d    = cd_q;
        armed_d = armed_q | ~overlap_q;
`endif
        case (state_q)
            ST_PLAY: begin
                if (hit_ok) begin
                    hit_d = 1'b1;
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        state_d = ST_HIT;
`ifdef HIT_COOLDOWN_EN
                        cd_d    = COOLDOWN_TICKS;
`endif
                    end else begin
                        lives_d = 3'd0;
                        state_d = ST_OVER;
                    end
                end
            end
            ST_HIT: begin
`ifdef HIT_COOLDOWN_EN
                if (game_en) begin
                    cd_d = cd_q - 6'd1;
                    if (cd_q == 6'd1) begin
                        state_d = ST_PLAY;
                        armed_d = 1'b0;
                    end
                end
`else
                if (game_en && !overlap_q)
                    state_d = ST_PLAY;
`endif
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_PLAY;
        endcase

        // A wrap still scores in the clk that moves PLAY to HIT, but not
        // in the clk that moves PLAY to OVER.
        if (state_q == ST_PLAY && wrap && state_d != ST_OVER &&
            score_q != '1)
            score_d = score_q + SCORE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state_q     <= ST_PLAY;
            lives_q     <= START_LIVES;
            score_q     <= '0;
            hit_q       <= 1'b0;
            collision_q <= 1'b0;
            game_over_q <= 1'b0;
            overlap_q   <= 1'b0;
            y_q         <= '0;
`ifdef HIT_COOLDOWN_EN
            cd_q        <= '0;
            armed_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            hit_q       <= hit_d;
            collision_q <= (state_d != ST_PLAY);
            game_over_q <= (state_d == ST_OVER);
            overlap_q   <= overlap;
            y_q         <= obstacle_y_pos;
`ifdef HIT_COOLDOWN_EN
            cd_q        <= cd_d;
            armed_q     <= armed_d;
`endif
        end
    end

    assign collision = collision_q;
    assign game_over = game_over_q;
    assign hit_pulse = hit_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign state     = state_q;

endmodule
